// File: rtl/regfile_2w2r_scoreboard.sv
// Two-write/two-read register file with per-register busy scoreboard; combinational reads.
// Optional same-cycle write-to-read bypass when REGFILE_WRITE_BYPASS_EN is defined.
module regfile_2w2r_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_A_i,
  input  logic [ADDR_WIDTH-1:0] Write_Register_A_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_A_i,
  input  logic                  Reg_Write_B_i,
  input  logic [ADDR_WIDTH-1:0] Write_Register_B_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_B_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o,
  input  logic                  Reserve_i,
  input  logic [ADDR_WIDTH-1:0] Reserve_Register_i,
  output logic                  Busy_1_o,
  output logic                  Busy_2_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic                  wr_a_ok;
  logic                  wr_b_ok;
  logic                  rsv_ok;
  logic [ADDR_WIDTH-1:0] raddr [2];
  logic [DATA_WIDTH-1:0] rdata [2];
  logic                  rbusy [2];

  // Register 0 is never written or reserved when hardwired, so it stays zero.
  assign wr_a_ok = Reg_Write_A_i && !((ZERO_REG != 0) && (Write_Register_A_i == '0));
  assign wr_b_ok = Reg_Write_B_i && !((ZERO_REG != 0) && (Write_Register_B_i == '0));
  assign rsv_ok  = Reserve_i     && !((ZERO_REG != 0) && (Reserve_Register_i == '0));

  // Writes clear busy first, then a same-cycle reserve re-sets it.
  always_comb begin
    busy_next = busy;
    if (Reg_Write_A_i) busy_next[Write_Register_A_i] = 1'b0;
    if (Reg_Write_B_i) busy_next[Write_Register_B_i] = 1'b0;
    if (rsv_ok)        busy_next[Reserve_Register_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_a_ok) regs[Write_Register_A_i] <= Write_Data_A_i;
      // Port B assigned last so it wins on an address collision.
      if (wr_b_ok) regs[Write_Register_B_i] <= Write_Data_B_i;
      busy <= busy_next;
    end
  end

  assign raddr[0] = Read_Register_1_i;
  assign raddr[1] = Read_Register_2_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs[raddr[p]];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_a_ok && (Write_Register_A_i == raddr[p])) rdata[p] = Write_Data_A_i;
      if (wr_b_ok && (Write_Register_B_i == raddr[p])) rdata[p] = Write_Data_B_i;
`endif
      rbusy[p] = busy[raddr[p]];
      // Outputs are forced low while reset is held, bypass path included.
      if (!reset) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign Read_Data_1_o = rdata[0];
  assign Read_Data_2_o = rdata[1];
  assign Busy_1_o      = rbusy[0];
  assign Busy_2_o      = rbusy[1];

endmodule

// File: tb/tb_regfile_2w2r_scoreboard.sv
// Randomized + directed bench for regfile_2w2r_scoreboard against an array-based reference model.
module tb_regfile_2w2r_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;
`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          Reg_Write_A_i, Reg_Write_B_i, Reserve_i;
  logic [AW-1:0] Write_Register_A_i, Write_Register_B_i, Reserve_Register_i;
  logic [AW-1:0] Read_Register_1_i, Read_Register_2_i;
  logic [DW-1:0] Write_Data_A_i, Write_Data_B_i;
  logic [DW-1:0] Read_Data_1_o, Read_Data_2_o;
  logic          Busy_1_o, Busy_2_o;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [DW-1:0] m_regs [DEPTH];
  bit            m_busy [DEPTH];

  regfile_2w2r_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .Reg_Write_A_i(Reg_Write_A_i), .Write_Register_A_i(Write_Register_A_i), .Write_Data_A_i(Write_Data_A_i),
    .Reg_Write_B_i(Reg_Write_B_i), .Write_Register_B_i(Write_Register_B_i), .Write_Data_B_i(Write_Data_B_i),
    .Read_Register_1_i(Read_Register_1_i), .Read_Register_2_i(Read_Register_2_i),
    .Read_Data_1_o(Read_Data_1_o), .Read_Data_2_o(Read_Data_2_o),
    .Reserve_i(Reserve_i), .Reserve_Register_i(Reserve_Register_i),
    .Busy_1_o(Busy_1_o), .Busy_2_o(Busy_2_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents and pending flags.
  always @(negedge reset) begin
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      if (Reg_Write_A_i && Write_Register_A_i != 0) m_regs[Write_Register_A_i] = Write_Data_A_i;
      if (Reg_Write_B_i && Write_Register_B_i != 0) m_regs[Write_Register_B_i] = Write_Data_B_i;
      if (Reg_Write_A_i) m_busy[Write_Register_A_i] = 1'b0;
      if (Reg_Write_B_i) m_busy[Write_Register_B_i] = 1'b0;
      if (Reserve_i && Reserve_Register_i != 0) m_busy[Reserve_Register_i] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (reset !== 1'b1) return '0;
    v = m_regs[a];
    if (BYP && a != 0) begin
      if (Reg_Write_B_i && Write_Register_B_i == a) v = Write_Data_B_i;
      else if (Reg_Write_A_i && Write_Register_A_i == a) v = Write_Data_A_i;
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_busy(input logic [AW-1:0] a);
    if (reset !== 1'b1) return '0;
    return {{(DW-1){1'b0}}, m_busy[a]};
  endfunction

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      cmp("model_rd1",   Read_Data_1_o, exp_rd(Read_Register_1_i));
      cmp("model_rd2",   Read_Data_2_o, exp_rd(Read_Register_2_i));
      cmp("model_busy1", {{(DW-1){1'b0}}, Busy_1_o}, exp_busy(Read_Register_1_i));
      cmp("model_busy2", {{(DW-1){1'b0}}, Busy_2_o}, exp_busy(Read_Register_2_i));
    end
  end

  task automatic idle();
    Reg_Write_A_i = 0; Write_Register_A_i = '0; Write_Data_A_i = '0;
    Reg_Write_B_i = 0; Write_Register_B_i = '0; Write_Data_B_i = '0;
    Reserve_i = 0; Reserve_Register_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a1, input int a2);
    Read_Register_1_i = AW'(a1);
    Read_Register_2_i = AW'(a2);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1'b0;
    idle();
    rd(1, 2);
    check_en = 1'b1;
    #3;
    cmp("reset_rd1", Read_Data_1_o, 0);
    cmp("reset_busy1", {31'b0, Busy_1_o}, 0);

    // Parallel writes to two registers.
    @(posedge clk); #1;
    reset = 1'b1;
    Reg_Write_A_i = 1; Write_Register_A_i = 1; Write_Data_A_i = 100;
    Reg_Write_B_i = 1; Write_Register_B_i = 2; Write_Data_B_i = 88;
    step();
    idle(); rd(1, 2); #2;
    cmp("dual_wr_rd1", Read_Data_1_o, 100);
    cmp("dual_wr_rd2", Read_Data_2_o, 88);

    // Collision: B wins.
    Reg_Write_A_i = 1; Write_Register_A_i = 5; Write_Data_A_i = 77;
    Reg_Write_B_i = 1; Write_Register_B_i = 5; Write_Data_B_i = 20;
    step();
    idle(); rd(5, 0); #2;
    cmp("collide_b_wins", Read_Data_1_o, 20);

    // Hardwired zero register.
    Reg_Write_A_i = 1; Write_Register_A_i = 0; Write_Data_A_i = 66;
    step();
    idle(); rd(0, 0); #2;
    cmp("zero_rd", Read_Data_1_o, 0);
    cmp("zero_busy", {31'b0, Busy_1_o}, 0);
    Reserve_i = 1; Reserve_Register_i = 0;
    step();
    idle(); #2;
    cmp("zero_busy_after_rsv", {31'b0, Busy_2_o}, 0);

    // Scoreboard set / clear / reserve-wins.
    Reserve_i = 1; Reserve_Register_i = 7; rd(7, 7);
    step();
    idle(); #2;
    cmp("rsv7_busy", {31'b0, Busy_1_o}, 1);
    Reg_Write_B_i = 1; Write_Register_B_i = 7; Write_Data_B_i = 30;
    step();
    idle(); #2;
    cmp("wr7_clears_busy", {31'b0, Busy_1_o}, 0);
    cmp("wr7_data", Read_Data_1_o, 30);
    Reserve_i = 1; Reserve_Register_i = 7;
    Reg_Write_A_i = 1; Write_Register_A_i = 7; Write_Data_A_i = 15;
    step();
    idle(); #2;
    cmp("rsv_wr7_data", Read_Data_1_o, 15);
    cmp("rsv_wr7_busy", {31'b0, Busy_2_o}, 1);

    // Same-cycle write/read of reg3.
    Reg_Write_A_i = 1; Write_Register_A_i = 3; Write_Data_A_i = 27; rd(3, 3); #2;
    cmp("bypass_pre_edge", Read_Data_1_o, BYP ? 27 : 0);
    step();
    idle(); #2;
    cmp("post_edge_rd3", Read_Data_1_o, 27);

    // Load 1..10, reserve 4 and 8, then reset mid-cycle.
    for (int i = 0; i < 5; i++) begin
      Reg_Write_A_i = 1; Write_Register_A_i = AW'(2*i + 1); Write_Data_A_i = DW'(200 + 2*i + 1);
      Reg_Write_B_i = 1; Write_Register_B_i = AW'(2*i + 2); Write_Data_B_i = DW'(200 + 2*i + 2);
      Reserve_i = (i == 1 || i == 3); Reserve_Register_i = (i == 1) ? AW'(4) : AW'(8);
      step();
    end
    idle(); rd(4, 8); #2;
    cmp("load_rd4", Read_Data_1_o, 204);
    cmp("load_busy8", {31'b0, Busy_2_o}, 1);
    reset = 1'b0;
    Reg_Write_A_i = 1; Write_Register_A_i = 12; Write_Data_A_i = 55;
    #1;
    cmp("async_rst_rd4", Read_Data_1_o, 0);
    cmp("async_rst_rd8", Read_Data_2_o, 0);
    cmp("async_rst_busy4", {31'b0, Busy_1_o}, 0);
    cmp("async_rst_busy8", {31'b0, Busy_2_o}, 0);
    step();
    reset = 1'b1;
    idle(); rd(12, 4); #2;
    cmp("write_in_reset_lost", Read_Data_1_o, 0);
    cmp("post_rst_rd4", Read_Data_2_o, 0);
    Reg_Write_B_i = 1; Write_Register_B_i = 12; Write_Data_B_i = 9;
    step();
    idle(); #2;
    cmp("first_edge_after_rst", Read_Data_1_o, 9);

    // Randomized traffic, model-checked every cycle.
    for (int n = 0; n < 3000; n++) begin
      Reg_Write_A_i = ($urandom_range(0, 1) == 1);
      Write_Register_A_i = rand_addr();
      Write_Data_A_i = $urandom;
      Reg_Write_B_i = ($urandom_range(0, 2) == 0);
      Write_Register_B_i = rand_addr();
      Write_Data_B_i = $urandom;
      Reserve_i = ($urandom_range(0, 2) == 0);
      Reserve_Register_i = rand_addr();
      Read_Register_1_i = rand_addr();
      Read_Register_2_i = rand_addr();
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
      step();
    end

    idle();
    step();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_2w2r_scoreboard.md
REGFILE_2W2R_SCOREBOARD -- requirements
Module: regfile_2w2r_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning width of each register in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning register address width, so depth = 2^ADDR_WIDTH.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when set to 1.
REQ-004 The block SHALL have port clk, input, width 1, meaning the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have ports Reg_Write_A_i (input, 1), Write_Register_A_i (input, ADDR_WIDTH) and Write_Data_A_i (input, DATA_WIDTH), meaning write port A enable, address and data.
REQ-007 The block SHALL have ports Reg_Write_B_i (input, 1), Write_Register_B_i (input, ADDR_WIDTH) and Write_Data_B_i (input, DATA_WIDTH), meaning write port B enable, address and data.
REQ-008 The block SHALL have ports Read_Register_1_i and Read_Register_2_i (input, ADDR_WIDTH each), meaning read addresses.
REQ-009 The block SHALL have ports Read_Data_1_o and Read_Data_2_o (output, DATA_WIDTH each), meaning read data.
REQ-010 The block SHALL have ports Reserve_i (input, 1) and Reserve_Register_i (input, ADDR_WIDTH), meaning a request to mark the destination register as pending.
REQ-011 The block SHALL have ports Busy_1_o and Busy_2_o (output, 1 each), meaning the pending flag of each read address.

Function
REQ-012 Reads SHALL be combinational: Read_Data_n_o = reg[Read_Register_n_i], with zero added cycles of latency.
REQ-013 A write SHALL take effect on the rising clk edge when Reg_Write_X_i = 1; the new value is visible on the read ports from that edge onward.
REQ-014 Simultaneous writes from ports A and B to the same address SHALL resolve so that port B data is stored.
REQ-015 With ZERO_REG = 1, writes to address 0 SHALL be ignored, reads of address 0 SHALL return 0, and busy[0] SHALL always be 0.
REQ-016 The scoreboard SHALL hold one busy bit per register; Reserve_i = 1 sets busy[Reserve_Register_i] at the clk edge.
REQ-017 A write from either port SHALL clear the busy bit of the register it writes at the same edge.
REQ-018 When a reserve and a write target the same register in the same cycle, the data SHALL be written and busy SHALL end up 1, because the reserve wins.
REQ-019 Reserving a register that is already busy SHALL leave it busy, with no error and no count.
REQ-020 Busy_n_o SHALL equal the registered busy[Read_Register_n_i], with no same-cycle bypass of busy.
REQ-021 Addresses SHALL wrap naturally within ADDR_WIDTH bits, with no out-of-range behaviour.

Reset
REQ-022 When reset = 0, all registers and all busy bits SHALL clear to 0 immediately, without waiting for clk.
REQ-023 While reset = 0, Read_Data_1_o and Read_Data_2_o SHALL read 0 and Busy_1_o and Busy_2_o SHALL read 0, and writes and reserves SHALL be ignored.
REQ-024 A reset asserted mid-operation SHALL discard any write or reserve that has not yet reached its clk edge.
REQ-025 On release of reset, the first rising clk edge SHALL accept writes and reserves normally.

Configuration
REQ-026 With macro REGFILE_WRITE_BYPASS_EN defined, a read address that matches an enabled same-cycle write address SHALL return that write data combinationally, with port B taking priority when both ports match.
REQ-027 With REGFILE_WRITE_BYPASS_EN defined and ZERO_REG = 1, address 0 SHALL never be bypassed.
REQ-028 Without REGFILE_WRITE_BYPASS_EN, reads SHALL return the stored value only, so a same-cycle write becomes visible after the edge.

Verification
REQ-029 The bench SHALL cover this scenario: reset low, then high; write A reg1=100 and B reg2=88 in one cycle; next cycle read 1/2 -> 100/88.
REQ-030 The bench SHALL cover this scenario: A and B both write reg5 (A=77, B=20) in one cycle -> reg5 reads 20 after the edge.
REQ-031 The bench SHALL cover this scenario: write reg0=66 via A with ZERO_REG=1 -> reg0 reads 0 and Busy of reg0 = 0, including after Reserve_i on reg0.
REQ-032 The bench SHALL cover this scenario: reserve reg7 -> Busy = 1 next cycle; write reg7=30 via B -> Busy = 0; reserve and write reg7=15 in the same cycle -> reg7 = 15 and Busy = 1.
REQ-033 The bench SHALL cover this scenario: with bypass defined, write reg3=27 and read reg3 in the same cycle -> 27 before the edge; without bypass -> old value before the edge and 27 after.
REQ-034 The bench SHALL cover this scenario: load regs 1-10 and reserve regs 4 and 8, then drop reset low between clk edges -> all reads and busy flags are 0 immediately, and a write issued during reset is lost.
